// File: rtl/keycode_pkg.sv
// Shared types and constants for the keycode Avalon-MM writer.
package keycode_pkg;
  localparam int KEYCODE_W = 8;
  localparam logic [3:0] BYTEEN_KEY = 4'b0001;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;
endpackage

// File: rtl/keycode_fifo.sv
// Small synchronous FIFO with first-word fall-through output and registered occupancy.
module keycode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == (PTR_W+1)'(DEPTH));
  assign level = level_reg;
  assign dout  = mem[rd_ptr_reg];

  // A push into a full FIFO is legal only when a pop frees a slot on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end
endmodule

// File: rtl/keycode_avmm_writer.sv
// Avalon-MM initiator that writes each buffered keycode to a fixed responder address.
module keycode_avmm_writer
  import keycode_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int TARGET_ADDR = 0,
  parameter int FIFO_DEPTH  = 4,
  parameter int SKIP_REPEAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_strobe,
  input  logic [KEYCODE_W-1:0]          key_code,
  output logic [ADDR_W-1:0]             avm_address,
  output logic                          avm_write,
  output logic [31:0]                   avm_writedata,
  output logic [3:0]                    avm_byteenable,
  input  logic                          avm_waitrequest,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);
  state_t state_reg, state_next;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [KEYCODE_W-1:0]  fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic [KEYCODE_W-1:0]  last_code_reg;
  logic                  last_valid_reg;
  logic                  repeat_hit;
  logic                  want_push;
  logic                  drop;
  logic [7:0]            drop_count_reg;

  logic                  write_reg, write_next;
  logic [KEYCODE_W-1:0]  code_reg, code_next;

  keycode_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEYCODE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (key_code),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign repeat_hit = (SKIP_REPEAT != 0) && last_valid_reg && (key_code == last_code_reg);
  assign want_push  = key_strobe && !repeat_hit;
  assign fifo_push  = want_push && (!fifo_full || fifo_pop);
  assign drop       = want_push && fifo_full && !fifo_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_code_reg  <= '0;
      last_valid_reg <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      if (fifo_push) begin
        last_code_reg  <= key_code;
        last_valid_reg <= 1'b1;
      end
      if (drop && drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!fifo_empty) state_next = WRITE;
      WRITE:   if (!avm_waitrequest && fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pop decisions live here so a completing write can reload the next code on the same edge.
  always_comb begin
    fifo_pop   = 1'b0;
    write_next = write_reg;
    code_next  = code_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          write_next = 1'b1;
          code_next  = fifo_dout;
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            write_next = 1'b1;
            code_next  = fifo_dout;
          end else begin
            write_next = 1'b0;
          end
        end
      end
      default: write_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_reg <= 1'b0;
      code_reg  <= '0;
    end else begin
      write_reg <= write_next;
      code_reg  <= code_next;
    end
  end

  assign avm_address    = ADDR_W'(TARGET_ADDR);
  assign avm_write      = write_reg;
  assign avm_writedata  = {24'b0, code_reg};
  assign avm_byteenable = BYTEEN_KEY;
  assign drop_count     = drop_count_reg;
endmodule

// File: tb/tb_keycode_avmm_writer.sv
// Directed self-checking bench for keycode_avmm_writer (repeat filter on and off).
module tb_keycode_avmm_writer;
  localparam int ADDR_W = 4;
  localparam int TADDR  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_strobe = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        avm_waitrequest = 1'b0;

  logic [ADDR_W-1:0] avm_address, nr_address;
  logic              avm_write, nr_write;
  logic [31:0]       avm_writedata, nr_writedata;
  logic [3:0]        avm_byteenable, nr_byteenable;
  logic [2:0]        fifo_level, nr_level;
  logic [7:0]        drop_count, nr_drop;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] wr_q[$];
  logic [7:0] nr_q[$];

  always #5 clk = ~clk;

  keycode_avmm_writer #(.ADDR_W(ADDR_W), .TARGET_ADDR(TADDR), .FIFO_DEPTH(4), .SKIP_REPEAT(1)) dut (
    .clk(clk), .reset(reset), .key_strobe(key_strobe), .key_code(key_code),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  keycode_avmm_writer #(.ADDR_W(ADDR_W), .TARGET_ADDR(TADDR), .FIFO_DEPTH(4), .SKIP_REPEAT(0)) dut_nr (
    .clk(clk), .reset(reset), .key_strobe(key_strobe), .key_code(key_code),
    .avm_address(nr_address), .avm_write(nr_write), .avm_writedata(nr_writedata),
    .avm_byteenable(nr_byteenable), .avm_waitrequest(avm_waitrequest),
    .fifo_level(nr_level), .drop_count(nr_drop)
  );

  // A write seen with waitrequest low at the falling edge is accepted on the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (avm_write && !avm_waitrequest) wr_q.push_back(avm_writedata[7:0]);
      if (nr_write && !avm_waitrequest)  nr_q.push_back(nr_writedata[7:0]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] c);
    key_strobe = 1'b1;
    key_code   = c;
    tick();
    key_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    wr_q.delete();
    nr_q.delete();
  endtask

  initial begin
    logic [7:0] exp4 [3];
    logic [7:0] exp4nr [4];
    exp4   = '{8'h1C, 8'h00, 8'h1C};
    exp4nr = '{8'h1C, 8'h1C, 8'h00, 8'h1C};

    // Reset state
    do_reset();
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_data", avm_writedata, 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);

    // 1. Single key, no stall
    avm_waitrequest = 1'b0;
    strobe(8'h1C);
    check("t1_write_E", 32'(avm_write), 32'd0);
    check("t1_level_E", 32'(fifo_level), 32'd1);
    tick();
    check("t1_write_E1", 32'(avm_write), 32'd1);
    check("t1_data", avm_writedata, 32'h0000001C);
    check("t1_addr", 32'(avm_address), 32'(TADDR));
    check("t1_byteen", 32'(avm_byteenable), 32'h1);
    check("t1_level_E1", 32'(fifo_level), 32'd0);
    tick();
    check("t1_write_done", 32'(avm_write), 32'd0);
    check("t1_count", 32'(wr_q.size()), 32'd1);

    // 2. Stall for 5 cycles
    do_reset();
    avm_waitrequest = 1'b1;
    strobe(8'h23);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_hold_write%0d", i), 32'(avm_write), 32'd1);
      check($sformatf("t2_hold_data%0d", i), avm_writedata, 32'h23);
      tick();
    end
    avm_waitrequest = 1'b0;
    check("t2_write_c6", 32'(avm_write), 32'd1);
    tick();
    check("t2_write_done", 32'(avm_write), 32'd0);
    check("t2_count", 32'(wr_q.size()), 32'd1);
    check("t2_level", 32'(fifo_level), 32'd0);

    // 3. Overflow
    do_reset();
    avm_waitrequest = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      key_strobe = 1'b1;
      key_code   = 8'(c);
      tick();
    end
    key_strobe = 1'b0;
    check("t3_drop", 32'(drop_count), 32'd1);
    check("t3_level", 32'(fifo_level), 32'd4);
    check("t3_inflight", avm_writedata, 32'h01);
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("t3_count", 32'(wr_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_q.size(); i++)
      check($sformatf("t3_order%0d", i), 32'(wr_q[i]), 32'(i + 1));
    check("t3_drop_after", 32'(drop_count), 32'd1);

    // 4. Repeat filter (dut) versus no filter (dut_nr)
    do_reset();
    strobe(8'h1C);
    strobe(8'h1C);
    strobe(8'h00);
    strobe(8'h1C);
    for (int i = 0; i < 8; i++) tick();
    check("t4_count_skip", 32'(wr_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_q.size(); i++)
      check($sformatf("t4_skip%0d", i), 32'(wr_q[i]), 32'(exp4[i]));
    check("t4_count_noskip", 32'(nr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < nr_q.size(); i++)
      check($sformatf("t4_noskip%0d", i), 32'(nr_q[i]), 32'(exp4nr[i]));

    // 5. Back-to-back
    do_reset();
    avm_waitrequest = 1'b1;
    strobe(8'h41);
    strobe(8'h42);
    strobe(8'h43);
    check("t5_level", 32'(fifo_level), 32'd2);
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_write%0d", i), 32'(avm_write), 32'd1);
      check($sformatf("t5_data%0d", i), avm_writedata, 32'(8'h41 + i));
      tick();
    end
    check("t5_write_end", 32'(avm_write), 32'd0);

    // 6. Reset mid-write
    do_reset();
    avm_waitrequest = 1'b1;
    strobe(8'h51);
    strobe(8'h52);
    strobe(8'h53);
    check("t6_pre_write", 32'(avm_write), 32'd1);
    check("t6_pre_level", 32'(fifo_level), 32'd2);
    reset = 1'b1;
    #1;
    check("t6_rst_write", 32'(avm_write), 32'd0);
    check("t6_rst_level", 32'(fifo_level), 32'd0);
    check("t6_rst_drop", 32'(drop_count), 32'd0);
    check("t6_rst_data", avm_writedata, 32'd0);
    tick();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    wr_q.delete();
    for (int i = 0; i < 5; i++) tick();
    check("t6_quiet_count", 32'(wr_q.size()), 32'd0);
    check("t6_quiet_write", 32'(avm_write), 32'd0);
    strobe(8'h60);
    for (int i = 0; i < 3; i++) tick();
    check("t6_new_count", 32'(wr_q.size()), 32'd1);
    check("t6_new_data", avm_writedata, 32'h60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
